// File: rtl/rcb_arb.sv
// rcb_arb: arbiter for one single-port config/lookup RAM shared between
// latency-critical lookup reads (priority) and host configuration writes.
// A pending host write may lose at most MAX_WR_WAIT slots to reads before
// it is forced onto the RAM port.
module rcb_arb #(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 128,
  parameter int BE_W        = DATA_W / 8,
  parameter int RD_LAT      = 2,
  parameter int MAX_WR_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              lu_rd_valid,
  input  logic [ADDR_W-1:0] lu_rd_addr,
  output logic              lu_rd_ready,
  output logic              lu_rsp_valid,
  output logic [DATA_W-1:0] lu_rsp_data,
  input  logic              hpb_wr_req,
  input  logic [ADDR_W-1:0] hpb_wr_addr,
  input  logic [DATA_W-1:0] hpb_wr_data,
  input  logic [BE_W-1:0]   hpb_wr_byte_en,
  output logic              rcb_wr_done,
  output logic              ram_en,
  output logic              ram_we,
  output logic [BE_W-1:0]   ram_be,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wr_data,
  input  logic [DATA_W-1:0] ram_rd_data
);

  localparam int CNT_W = (MAX_WR_WAIT < 1) ? 1 : $clog2(MAX_WR_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WR_WAIT);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WR_PEND   = 2'd1,
    WR_DONE   = 2'd2,
    WAIT_DROP = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]  wr_data_q, wr_data_d;
  logic [BE_W-1:0]    wr_be_q, wr_be_d;
  logic [ADDR_W-1:0]  ram_addr_q;
  logic [DATA_W-1:0]  ram_wr_data_q;
  logic [BE_W-1:0]    ram_be_q;
  logic [RD_LAT-1:0]  vld_q;

  logic wr_slot;   // this cycle is the write's RAM slot
  logic force_wr;  // write takes the slot from a waiting read
  logic rd_issue;
  logic wr_issue;

  // Next-state logic: capture in IDLE, arbitrate in WR_PEND, handshake after.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    wr_be_d    = wr_be_q;
    wr_slot    = 1'b0;
    force_wr   = 1'b0;
    case (state_q)
      IDLE: begin
        if (hpb_wr_req) begin
          wr_addr_d  = hpb_wr_addr;
          wr_data_d  = hpb_wr_data;
          wr_be_d    = hpb_wr_byte_en;
          wait_cnt_d = '0;
          state_d    = WR_PEND;
        end
      end
      WR_PEND: begin
        if (!lu_rd_valid || (wait_cnt_q == CNT_MAX)) begin
          wr_slot  = 1'b1;
          force_wr = lu_rd_valid;
          state_d  = WR_DONE;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      WR_DONE: begin
        state_d = WAIT_DROP;
      end
      WAIT_DROP: begin
        // A level request still held high must not be captured again.
        if (!hpb_wr_req) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // RAM port mux: a read or a write, never both; address/data/be hold when idle.
  always_comb begin
    lu_rd_ready = reset_n & ~force_wr;
    rd_issue    = lu_rd_valid & lu_rd_ready;
    wr_issue    = wr_slot & (|wr_be_q);
    ram_en      = rd_issue | wr_issue;
    ram_we      = wr_issue;
    ram_addr    = ram_addr_q;
    ram_wr_data = ram_wr_data_q;
    ram_be      = ram_be_q;
    if (rd_issue) begin
      ram_addr = lu_rd_addr;
    end else if (wr_issue) begin
      ram_addr    = wr_addr_q;
      ram_wr_data = wr_data_q;
      ram_be      = wr_be_q;
    end
  end

  // Response path: valid delayed by RD_LAT, data zeroed when not valid.
  always_comb begin
    lu_rsp_valid = vld_q[RD_LAT-1];
    lu_rsp_data  = lu_rsp_valid ? ram_rd_data : '0;
    rcb_wr_done  = (state_q == WR_DONE);
  end

  // FSM state, wait counter and captured write registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_be_q    <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      wr_be_q    <= wr_be_d;
    end
  end

  // Held RAM address/data/byte-enable for idle cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ram_addr_q    <= '0;
      ram_wr_data_q <= '0;
      ram_be_q      <= '0;
    end else begin
      ram_addr_q    <= ram_addr;
      ram_wr_data_q <= ram_wr_data;
      ram_be_q      <= ram_be;
    end
  end

  // Read-valid shift register; reset flushes in-flight responses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= rd_issue;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
      end
    end
  end

endmodule

// File: tb/tb_rcb_arb.sv
// Testbench for rcb_arb: directed stimulus, a RAM with RD_LAT read latency,
// and a cycle-level reference model of the arbitration rules.
module tb_rcb_arb;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 128;
  localparam int BE_W   = 16;
  localparam int RD_LAT = 2;
  localparam int MAXW   = 4;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              lu_rd_valid;
  logic [ADDR_W-1:0] lu_rd_addr;
  logic              lu_rd_ready;
  logic              lu_rsp_valid;
  logic [DATA_W-1:0] lu_rsp_data;
  logic              hpb_wr_req;
  logic [ADDR_W-1:0] hpb_wr_addr;
  logic [DATA_W-1:0] hpb_wr_data;
  logic [BE_W-1:0]   hpb_wr_byte_en;
  logic              rcb_wr_done;
  logic              ram_en;
  logic              ram_we;
  logic [BE_W-1:0]   ram_be;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wr_data;
  logic [DATA_W-1:0] ram_rd_data;

  always #5 clk = ~clk;

  rcb_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W), .RD_LAT(RD_LAT),
            .MAX_WR_WAIT(MAXW)) dut (
    .clk(clk), .reset_n(reset_n),
    .lu_rd_valid(lu_rd_valid), .lu_rd_addr(lu_rd_addr), .lu_rd_ready(lu_rd_ready),
    .lu_rsp_valid(lu_rsp_valid), .lu_rsp_data(lu_rsp_data),
    .hpb_wr_req(hpb_wr_req), .hpb_wr_addr(hpb_wr_addr), .hpb_wr_data(hpb_wr_data),
    .hpb_wr_byte_en(hpb_wr_byte_en), .rcb_wr_done(rcb_wr_done),
    .ram_en(ram_en), .ram_we(ram_we), .ram_be(ram_be), .ram_addr(ram_addr),
    .ram_wr_data(ram_wr_data), .ram_rd_data(ram_rd_data)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_wr_ev = 0;
  int n_done_ev = 0;

  task automatic chkw(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %b expected %b", nm, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // RAM behind the DUT: byte-enabled writes, RD_LAT-cycle read pipe.
  logic [DATA_W-1:0] ram_mem [0:1023];
  logic [DATA_W-1:0] rd_pipe [0:RD_LAT-1];
  logic              ram_loaded = 1'b0;
  assign ram_rd_data = rd_pipe[RD_LAT-1];

  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int a = 0; a < 1024; a++) ram_mem[a] <= 128'(a * 3);
      ram_loaded <= 1'b1;
    end else if (ram_en && ram_we) begin
      for (int b = 0; b < BE_W; b++)
        if (ram_be[b]) ram_mem[ram_addr][b*8 +: 8] <= ram_wr_data[b*8 +: 8];
    end
    rd_pipe[0] <= (ram_en && !ram_we) ? ram_mem[ram_addr] : '0;
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  // Reference model state.
  typedef struct { int due; logic [DATA_W-1:0] d; } rsp_t;
  rsp_t              rq[$];
  logic [DATA_W-1:0] model_mem [0:1023];
  bit                model_loaded = 1'b0;
  bit                m_pend, m_done_due, m_need_drop;
  int                m_losses;
  logic [ADDR_W-1:0] cap_addr, last_addr;
  logic [DATA_W-1:0] cap_data, last_data;
  logic [BE_W-1:0]   cap_be, last_be;

  // Compare every cycle against the model, then advance the model.
  always @(negedge clk) begin
    bit wr_now, rd_now, wr_ram, e_ready, e_rv, o_pend, o_done, o_drop;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_data, e_rd;
    logic [BE_W-1:0]   e_be;
    rsp_t r;
    if (!model_loaded) begin
      for (int a = 0; a < 1024; a++) model_mem[a] = 128'(a * 3);
      model_loaded = 1'b1;
    end
    if (ram_en && ram_we) n_wr_ev++;
    if (rcb_wr_done) n_done_ev++;
    if (!reset_n) begin
      rq.delete();
      m_pend = 0; m_done_due = 0; m_need_drop = 0; m_losses = 0;
      cap_addr = '0; cap_data = '0; cap_be = '0;
      last_addr = '0; last_data = '0; last_be = '0;
      chk1("rst_ready", lu_rd_ready, 1'b0);
      chk1("rst_rsp_valid", lu_rsp_valid, 1'b0);
      chk1("rst_done", rcb_wr_done, 1'b0);
      chk1("rst_ram_en", ram_en, 1'b0);
      chk1("rst_ram_we", ram_we, 1'b0);
      chkw("rst_ram_addr", 128'(ram_addr), 128'h0);
      chkw("rst_ram_be", 128'(ram_be), 128'h0);
      chkw("rst_ram_wdata", ram_wr_data, 128'h0);
      chkw("rst_rsp_data", lu_rsp_data, 128'h0);
    end else begin
      wr_now  = m_pend && (!lu_rd_valid || m_losses == MAXW);
      e_ready = !(wr_now && lu_rd_valid);
      rd_now  = lu_rd_valid && e_ready;
      wr_ram  = wr_now && (cap_be != '0);
      e_addr  = rd_now ? lu_rd_addr : (wr_ram ? cap_addr : last_addr);
      e_data  = wr_ram ? cap_data : last_data;
      e_be    = wr_ram ? cap_be : last_be;
      e_rv    = (rq.size() > 0) && (rq[0].due == cyc);
      e_rd    = e_rv ? rq[0].d : '0;
      chk1("mon_ready", lu_rd_ready, e_ready);
      chk1("mon_ram_en", ram_en, rd_now || wr_ram);
      chk1("mon_ram_we", ram_we, wr_ram);
      chkw("mon_ram_addr", 128'(ram_addr), 128'(e_addr));
      chkw("mon_ram_be", 128'(ram_be), 128'(e_be));
      chkw("mon_ram_wdata", ram_wr_data, e_data);
      chk1("mon_done", rcb_wr_done, m_done_due);
      chk1("mon_rsp_valid", lu_rsp_valid, e_rv);
      if (e_rv) begin
        chkw("mon_rsp_data", lu_rsp_data, e_rd);
        void'(rq.pop_front());
      end
      if (rd_now) begin
        r.due = cyc + RD_LAT;
        r.d   = model_mem[lu_rd_addr];
        rq.push_back(r);
      end
      if (wr_ram)
        for (int b = 0; b < BE_W; b++)
          if (cap_be[b]) model_mem[cap_addr][b*8 +: 8] = cap_data[b*8 +: 8];
      last_addr = e_addr; last_data = e_data; last_be = e_be;
      o_pend = m_pend; o_done = m_done_due; o_drop = m_need_drop;
      if (o_drop && !hpb_wr_req) m_need_drop = 0;
      if (o_done) m_need_drop = 1;
      m_done_due = wr_now;
      if (o_pend) begin
        if (wr_now) m_pend = 0;
        else m_losses++;
      end else if (!o_done && !o_drop && hpb_wr_req) begin
        m_pend = 1; m_losses = 0;
        cap_addr = hpb_wr_addr; cap_data = hpb_wr_data; cap_be = hpb_wr_byte_en;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int issued;
    int w0, d0;
    reset_n = 1'b0; lu_rd_valid = 1'b0; lu_rd_addr = '0;
    hpb_wr_req = 1'b0; hpb_wr_addr = '0; hpb_wr_data = '0; hpb_wr_byte_en = '0;

    // Reset state
    @(negedge clk);
    chk1("reset_ready", lu_rd_ready, 1'b0);
    chk1("reset_en", ram_en, 1'b0);
    tick(); tick(); reset_n = 1'b1;
    @(negedge clk);
    chk1("ready_after_reset", lu_rd_ready, 1'b1);

    // Single write, no reads; later changes to hpb_wr_* are ignored
    tick();
    hpb_wr_req = 1'b1; hpb_wr_addr = 10'h012;
    hpb_wr_data = {16{8'hA5}}; hpb_wr_byte_en = 16'hFFFF;
    @(negedge clk);
    chk1("t1_c0_en", ram_en, 1'b0);
    tick();
    hpb_wr_addr = 10'h3FF; hpb_wr_data = '0;
    @(negedge clk);
    chk1("t1_c1_we", ram_we, 1'b1);
    chk1("t1_c1_done", rcb_wr_done, 1'b0);
    chkw("t1_c1_addr", 128'(ram_addr), 128'h012);
    chkw("t1_c1_data", ram_wr_data, {16{8'hA5}});
    chkw("t1_c1_be", 128'(ram_be), 128'hFFFF);
    tick();
    @(negedge clk);
    chk1("t1_c2_done", rcb_wr_done, 1'b1);
    chk1("t1_c2_en", ram_en, 1'b0);
    tick(); hpb_wr_req = 1'b0;
    @(negedge clk);
    chk1("t1_c3_done", rcb_wr_done, 1'b0);
    tick(); tick();

    // Back-to-back reads of addresses 0..7, RD_LAT latency, data addr*3
    for (int i = 0; i < 11; i++) begin
      tick();
      lu_rd_valid = (i < 8); lu_rd_addr = 10'(i);
      @(negedge clk);
      if (i >= 2 && i < 10) begin
        chk1("lat_valid", lu_rsp_valid, 1'b1);
        chkw("lat_data", lu_rsp_data, 128'((i - 2) * 3));
      end else begin
        chk1("lat_idle", lu_rsp_valid, 1'b0);
      end
    end

    // Continuous reads with a write pending: 4 reads win, then the write is forced
    issued = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      lu_rd_valid = (issued < 10); lu_rd_addr = 10'(32 + issued);
      if (k == 0) begin
        hpb_wr_req = 1'b1; hpb_wr_addr = 10'h040;
        hpb_wr_data = {4{32'hDEADBEEF}}; hpb_wr_byte_en = 16'hFFFF;
      end
      if (k == 7) hpb_wr_req = 1'b0;
      @(negedge clk);
      if (k >= 1 && k <= 4) chk1("cr_read_wins", lu_rd_ready, 1'b1);
      if (k == 5) begin
        chk1("cr_forced_ready", lu_rd_ready, 1'b0);
        chk1("cr_forced_we", ram_we, 1'b1);
        chkw("cr_forced_addr", 128'(ram_addr), 128'h040);
      end
      if (k == 6) begin
        chk1("cr_done", rcb_wr_done, 1'b1);
        chk1("cr_stalled_rd_we", ram_we, 1'b0);
        chkw("cr_stalled_rd_addr", 128'(ram_addr), 128'h025);
      end
      if (lu_rd_valid && lu_rd_ready) issued++;
    end
    tick(); lu_rd_valid = 1'b0;
    tick(); tick(); tick();

    // Held request: one write and one done; a new request after the drop writes again
    w0 = n_wr_ev; d0 = n_done_ev;
    tick();
    hpb_wr_req = 1'b1; hpb_wr_addr = 10'h100;
    hpb_wr_data = {8{16'h1234}}; hpb_wr_byte_en = 16'hFFFF;
    repeat (9) tick();
    hpb_wr_req = 1'b0;
    tick(); tick();
    chkw("held_writes", 128'(n_wr_ev - w0), 128'd1);
    chkw("held_dones", 128'(n_done_ev - d0), 128'd1);
    hpb_wr_req = 1'b1; hpb_wr_data = {8{16'h4321}};
    tick(); tick(); tick();
    hpb_wr_req = 1'b0;
    tick(); tick();
    chkw("rereq_writes", 128'(n_wr_ev - w0), 128'd2);
    chkw("rereq_dones", 128'(n_done_ev - d0), 128'd2);

    // Zero byte enable: no RAM access, done still at cycle 2
    tick();
    hpb_wr_req = 1'b1; hpb_wr_addr = 10'h005; hpb_wr_data = '1; hpb_wr_byte_en = '0;
    tick();
    @(negedge clk);
    chk1("zbe_no_en", ram_en, 1'b0);
    tick();
    @(negedge clk);
    chk1("zbe_done", rcb_wr_done, 1'b1);
    tick(); hpb_wr_req = 1'b0;
    tick();
    // Partial byte enable: only bytes 0..3 of address 5 change
    tick();
    hpb_wr_req = 1'b1; hpb_wr_byte_en = 16'h000F;
    tick(); tick(); tick();
    hpb_wr_req = 1'b0;
    tick();
    lu_rd_valid = 1'b1; lu_rd_addr = 10'h005;
    tick(); lu_rd_valid = 1'b0;
    tick();
    @(negedge clk);
    chk1("pbe_rsp_valid", lu_rsp_valid, 1'b1);
    chkw("pbe_rsp_data", lu_rsp_data, 128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF);
    tick(); tick();

    // Reset while the write is pending behind reads
    tick();
    hpb_wr_req = 1'b1; hpb_wr_addr = 10'h0AA; hpb_wr_data = {16{8'h5A}};
    hpb_wr_byte_en = 16'hFFFF; lu_rd_valid = 1'b1; lu_rd_addr = 10'h030;
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    chk1("mid_rst_ready", lu_rd_ready, 1'b0);
    chk1("mid_rst_rsp_valid", lu_rsp_valid, 1'b0);
    chk1("mid_rst_en", ram_en, 1'b0);
    chk1("mid_rst_done", rcb_wr_done, 1'b0);
    chkw("mid_rst_addr", 128'(ram_addr), 128'h0);
    lu_rd_valid = 1'b0; hpb_wr_req = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk1("post_rst_rsp_valid", lu_rsp_valid, 1'b0);
      chk1("post_rst_done", rcb_wr_done, 1'b0);
      tick();
    end
    hpb_wr_req = 1'b1;
    tick();
    @(negedge clk);
    chk1("post_rst_we", ram_we, 1'b1);
    chkw("post_rst_addr", 128'(ram_addr), 128'h0AA);
    tick();
    @(negedge clk);
    chk1("post_rst_wr_done", rcb_wr_done, 1'b1);
    tick(); hpb_wr_req = 1'b0;
    tick(); tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
